pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Registered, parametrised program-counter sequencer. It is the next generation of the combinational next-PC selector.
- Owns the PC register, a hardware return-address stack of configurable depth, and an interrupt-entry/return mechanism.
- Branch offsets are signed, so backward branches work.
- Sits between instruction decode (op, offset, jump address, flags) and instruction fetch (pc_o).

Parameters:
PC_W, 12, PC / address width in bits
OFF_W, 8, branch offset width in bits; two's complement, sign-extended to PC_W
STACK_DEPTH, 4, number of return-stack entries (>=2)
RESET_VEC, 12'h000, PC value after reset
INT_VEC, 12'hFF0, PC loaded on interrupt entry

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_n_i  in  1  synchronous active-low reset
step_i  in  1  advance enable; 0 = hold all state (stall)
op_i  in  4  PC operation (encoding below)
zero_i  in  1  ALU zero flag
carry_i  in  1  ALU carry flag
offset_i  in  OFF_W  signed branch displacement
jump_i  in  PC_W  absolute jump/call target
irq_i  in  1  level-sensitive interrupt request
pc_o  out  PC_W  current PC (registered)
stk_depth_o  out  $clog2(STACK_DEPTH+1)  entries currently on stack
int_en_o  out  1  interrupt enable state
int_ack_o  out  1  one-cycle pulse on interrupt entry
stk_ovf_o  out  1  sticky: push attempted while full
stk_unf_o  out  1  sticky: pop attempted while empty
illegal_o  out  1  one-cycle pulse on reserved op

Behaviour:
Synchronous reset, checked before everything else:
- If rst_n_i=0 at a clock edge: pc_o=RESET_VEC, stk_depth_o=0, int_en_o=0, int_ack_o=0, stk_ovf_o=0, stk_unf_o=0, illegal_o=0.
- Reset takes effect regardless of step_i. It aborts any in-flight op; stack contents are don't-care.

Stall:
- step_i=0: PC, stack, flags and int_en all hold.
- int_ack_o and illegal_o go 0.
- irq_i is not sampled.

Latency: one cycle. An op presented with step_i=1 is reflected on pc_o after the next rising edge.

Arithmetic:
- All PC math is modulo 2^PC_W; wrap-around is silent.
- Branch target = pc_o + sext(offset_i).
- Sequential next = pc_o + 1.

op_i encoding, evaluated only when step_i=1 and no interrupt is taken:
- 0000 SEQ: PC+1.
- 01cc BRANCH: condition cc=00 zero_i, 01 ~zero_i, 10 carry_i, 11 ~carry_i. Taken -> branch target; not taken -> PC+1.
- 1000 JUMP: PC=jump_i.
- 1001 CALL: push PC+1; PC=jump_i.
- 1010 RET: PC=pop.
- 1011 RETI: PC=pop; int_en=1.
- 1100 EI: int_en=1; PC+1.
- 1101 DI: int_en=0; PC+1.
- 0001-0011, 1110, 1111 reserved: PC+1; illegal_o=1 for one cycle.

Interrupt:
- Taken when step_i=1 and irq_i=1 and int_en=1; it has priority over op_i.
- The current op is discarded: no flag or stack effect from it, and illegal_o stays 0.
- Action: push pc_o (the un-executed instruction), PC=INT_VEC, int_en=0, int_ack_o=1 for one cycle.
- No nesting is possible until software issues EI or RETI.
- EI and the irq are resolved in order: EI sets int_en at the edge, so an irq can be taken on the following step.

Return stack (LIFO, STACK_DEPTH entries):
- Push when full: the push is dropped and stk_ovf_o is set. The PC still moves to jump_i or INT_VEC; depth is unchanged.
- Pop when empty: PC=PC+1 and stk_unf_o is set; depth stays 0. RETI still sets int_en.
- stk_ovf_o and stk_unf_o are cleared only by reset.
- Push and pop never occur in the same cycle.

Test Plan:
Defaults for all scenarios: PC_W=12, OFF_W=8, STACK_DEPTH=4, RESET_VEC=0, INT_VEC=0xFF0.
- Reset then 3x SEQ with step_i=1, plus one stall cycle -> pc_o 0x000,0x001,0x002,0x003; pc_o holds 0x003 across the stall; mid-sequence rst_n_i=0 -> next pc_o=0x000 and all flags 0.
- pc_o=0x010, BRANCH cc=00, zero_i=1, offset=0xFC -> pc_o=0x00C. Same setup with zero_i=0 -> 0x011. pc_o=0xFFF, SEQ -> 0x000 (wrap).
- CALL 0x100 from 0x020, CALL 0x200 from 0x100, RET, RET -> pc_o 0x100, 0x200, 0x101, 0x021; stk_depth_o 1, 2, 1, 0.
- 5 CALLs from empty -> stk_depth_o=4, stk_ovf_o=1 after the 5th. Then 5 RETs -> 4 valid returns, then the 5th gives PC+1 and stk_unf_o=1; both flags remain 1 until reset.
- EI at 0x030, irq_i=1 with op=JUMP 0x400 at 0x031 -> pc_o=0xFF0, int_ack_o pulses, int_en_o=0, the jump is ignored. RETI -> pc_o=0x031, int_en_o=1.
- op_i=1110 at 0x050 -> pc_o=0x051 and illegal_o=1 for exactly one cycle. irq_i=1 with int_en=0 -> ignored.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered PC sequencer with return-address stack and single-level interrupt entry/return.
// One-cycle latency: an op accepted with step_i=1 shows on pc_o after the next edge; step_i=0 freezes all state.
module pc_sequencer #(
  parameter int              PC_W        = 12,
  parameter int              OFF_W       = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = 12'h000,
  parameter logic [PC_W-1:0] INT_VEC     = 12'hFF0,
  localparam int             DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             step_i,
  input  logic [3:0]       op_i,
  input  logic             zero_i,
  input  logic             carry_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [PC_W-1:0]  jump_i,
  input  logic             irq_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [DW-1:0]    stk_depth_o,
  output logic             int_en_o,
  output logic             int_ack_o,
  output logic             stk_ovf_o,
  output logic             stk_unf_o,
  output logic             illegal_o
);

  localparam int            IW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_stk [STACK_DEPTH];
  logic [DW-1:0]   r_depth;
  logic            r_int_en;
  logic            r_int_ack;
  logic            r_ovf;
  logic            r_unf;
  logic            r_illegal;

  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_br_target;
  logic            w_full;
  logic            w_empty;
  logic [IW-1:0]   w_top_idx;
  logic [IW-1:0]   w_push_idx;
  logic            w_irq_take;
  logic            w_taken;
  logic [PC_W-1:0] w_nxt_pc;
  logic            w_nxt_int_en;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_push_val;
  logic            w_illegal;

  assign w_seq       = r_pc + 1'b1;
  assign w_br_target = r_pc + {{(PC_W-OFF_W){offset_i[OFF_W-1]}}, offset_i};
  assign w_full      = (r_depth == FULL);
  assign w_empty     = (r_depth == '0);
  assign w_top_idx   = IW'(r_depth - 1'b1);
  assign w_push_idx  = IW'(r_depth);
  assign w_irq_take  = irq_i & r_int_en;

  always_comb begin
    case (op_i[1:0])
      2'b00:   w_taken = zero_i;
      2'b01:   w_taken = ~zero_i;
      2'b10:   w_taken = carry_i;
      default: w_taken = ~carry_i;
    endcase
  end

  always_comb begin
    w_nxt_pc     = w_seq;
    w_nxt_int_en = r_int_en;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_push_val   = w_seq;
    w_illegal    = 1'b0;
    if (w_irq_take) begin
      // Interrupt preempts the op; the un-executed PC is saved so RETI replays it.
      w_push       = 1'b1;
      w_push_val   = r_pc;
      w_nxt_pc     = INT_VEC;
      w_nxt_int_en = 1'b0;
    end else begin
      casez (op_i)
        4'b0000: w_nxt_pc = w_seq;
        4'b01??: w_nxt_pc = w_taken ? w_br_target : w_seq;
        4'b1000: w_nxt_pc = jump_i;
        4'b1001: begin
          w_push   = 1'b1;
          w_nxt_pc = jump_i;
        end
        4'b1010: begin
          w_pop    = 1'b1;
          w_nxt_pc = w_empty ? w_seq : r_stk[w_top_idx];
        end
        4'b1011: begin
          w_pop        = 1'b1;
          w_nxt_pc     = w_empty ? w_seq : r_stk[w_top_idx];
          w_nxt_int_en = 1'b1;
        end
        4'b1100: w_nxt_int_en = 1'b1;
        4'b1101: w_nxt_int_en = 1'b0;
        default: w_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_pc      <= RESET_VEC;
      r_depth   <= '0;
      r_int_en  <= 1'b0;
      r_int_ack <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (step_i) begin
      r_pc      <= w_nxt_pc;
      r_int_en  <= w_nxt_int_en;
      r_int_ack <= w_irq_take;
      r_illegal <= w_illegal;
      if (w_push && w_full)   r_ovf <= 1'b1;
      if (w_pop && w_empty)   r_unf <= 1'b1;
      if (w_push && !w_full)  r_depth <= r_depth + 1'b1;
      if (w_pop && !w_empty)  r_depth <= r_depth - 1'b1;
    end else begin
      r_int_ack <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  // Stack storage needs no reset; depth alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && step_i && w_push && !w_full) r_stk[w_push_idx] <= w_push_val;
  end

  assign pc_o        = r_pc;
  assign stk_depth_o = r_depth;
  assign int_en_o    = r_int_en;
  assign int_ack_o   = r_int_ack;
  assign stk_ovf_o   = r_ovf;
  assign stk_unf_o   = r_unf;
  assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        step_i;
  logic [3:0]  op_i;
  logic        zero_i;
  logic        carry_i;
  logic [7:0]  offset_i;
  logic [11:0] jump_i;
  logic        irq_i;
  logic [11:0] pc_o;
  logic [2:0]  stk_depth_o;
  logic        int_en_o;
  logic        int_ack_o;
  logic        stk_ovf_o;
  logic        stk_unf_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .step_i(step_i), .op_i(op_i),
    .zero_i(zero_i), .carry_i(carry_i), .offset_i(offset_i), .jump_i(jump_i),
    .irq_i(irq_i), .pc_o(pc_o), .stk_depth_o(stk_depth_o), .int_en_o(int_en_o),
    .int_ack_o(int_ack_o), .stk_ovf_o(stk_ovf_o), .stk_unf_o(stk_unf_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op with step_i=1, clock it, sample 1 time unit after the edge.
  task automatic op(input logic [3:0] o, input logic [11:0] j = 12'h000, input logic [7:0] off = 8'h00);
    op_i     = o;
    jump_i   = j;
    offset_i = off;
    step_i   = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic stall();
    step_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    op(4'b0000);
    rst_n_i = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},  pc_o, 12'h000);
    chk({tag, "_dep"}, stk_depth_o, 3'd0);
    chk({tag, "_ien"}, int_en_o, 1'b0);
    chk({tag, "_ack"}, int_ack_o, 1'b0);
    chk({tag, "_ovf"}, stk_ovf_o, 1'b0);
    chk({tag, "_unf"}, stk_unf_o, 1'b0);
    chk({tag, "_ill"}, illegal_o, 1'b0);
  endtask

  initial begin
    rst_n_i = 1'b0; step_i = 1'b0; op_i = 4'b0000; zero_i = 1'b0; carry_i = 1'b0;
    offset_i = 8'h00; jump_i = 12'h000; irq_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk_reset_state("rst0");
    rst_n_i = 1'b1;

    // Sequential stepping and stall
    op(4'b0000); chk("seq1", pc_o, 12'h001);
    op(4'b0000); chk("seq2", pc_o, 12'h002);
    op(4'b0000); chk("seq3", pc_o, 12'h003);
    stall();     chk("stall_hold", pc_o, 12'h003);
    do_reset();  chk_reset_state("rst_mid");

    // Branches, signed offset, wrap
    op(4'b1000, 12'h010); chk("jmp010", pc_o, 12'h010);
    zero_i = 1'b1;
    op(4'b0100, 12'h000, 8'hFC); chk("br_z_taken_back", pc_o, 12'h00C);
    op(4'b1000, 12'h010);
    zero_i = 1'b0;
    op(4'b0100, 12'h000, 8'hFC); chk("br_z_not_taken", pc_o, 12'h011);
    carry_i = 1'b1;
    op(4'b0110, 12'h000, 8'h05); chk("br_c_taken", pc_o, 12'h016);
    op(4'b0111, 12'h000, 8'h05); chk("br_nc_not_taken", pc_o, 12'h017);
    op(4'b0101, 12'h000, 8'h10); chk("br_nz_taken", pc_o, 12'h027);
    carry_i = 1'b0;
    op(4'b1000, 12'hFFF);
    op(4'b0000); chk("wrap", pc_o, 12'h000);

    // Nested call/return
    op(4'b1000, 12'h020);
    op(4'b1001, 12'h100); chk("call1_pc", pc_o, 12'h100); chk("call1_dep", stk_depth_o, 3'd1);
    op(4'b1001, 12'h200); chk("call2_pc", pc_o, 12'h200); chk("call2_dep", stk_depth_o, 3'd2);
    op(4'b1010);          chk("ret1_pc", pc_o, 12'h101);  chk("ret1_dep", stk_depth_o, 3'd1);
    op(4'b1010);          chk("ret2_pc", pc_o, 12'h021);  chk("ret2_dep", stk_depth_o, 3'd0);

    // Overflow then underflow
    op(4'b1001, 12'h100);
    op(4'b1001, 12'h200);
    op(4'b1001, 12'h300);
    op(4'b1001, 12'h400); chk("fill_dep", stk_depth_o, 3'd4); chk("fill_ovf", stk_ovf_o, 1'b0);
    op(4'b1001, 12'h500); chk("ovf_pc", pc_o, 12'h500); chk("ovf_dep", stk_depth_o, 3'd4);
    chk("ovf_flag", stk_ovf_o, 1'b1);
    op(4'b1010); chk("pop1", pc_o, 12'h301);
    op(4'b1010); chk("pop2", pc_o, 12'h201);
    op(4'b1010); chk("pop3", pc_o, 12'h101);
    op(4'b1010); chk("pop4", pc_o, 12'h022); chk("pop4_unf", stk_unf_o, 1'b0);
    op(4'b1010); chk("unf_pc", pc_o, 12'h023); chk("unf_dep", stk_depth_o, 3'd0);
    chk("unf_flag", stk_unf_o, 1'b1);
    op(4'b0000); chk("ovf_sticky", stk_ovf_o, 1'b1); chk("unf_sticky", stk_unf_o, 1'b1);
    do_reset();  chk_reset_state("rst_flags");

    // Interrupt entry and return
    op(4'b1000, 12'h030);
    op(4'b1100); chk("ei_pc", pc_o, 12'h031); chk("ei_en", int_en_o, 1'b1);
    irq_i = 1'b1;
    op(4'b1000, 12'h400); chk("irq_pc", pc_o, 12'hFF0); chk("irq_ack", int_ack_o, 1'b1);
    chk("irq_en", int_en_o, 1'b0); chk("irq_dep", stk_depth_o, 3'd1);
    op(4'b0000); chk("irq_masked_pc", pc_o, 12'hFF1); chk("ack_pulse_end", int_ack_o, 1'b0);
    irq_i = 1'b0;
    op(4'b1011); chk("reti_pc", pc_o, 12'h031); chk("reti_en", int_en_o, 1'b1);
    chk("reti_dep", stk_depth_o, 3'd0);

    // Reserved op, stalled irq, irq over reserved op, DI masking
    op(4'b1000, 12'h050);
    op(4'b1110); chk("ill_pc", pc_o, 12'h051); chk("ill_pulse", illegal_o, 1'b1);
    op(4'b0000); chk("ill_end_pc", pc_o, 12'h052); chk("ill_end", illegal_o, 1'b0);
    irq_i = 1'b1;
    stall(); chk("stall_irq_pc", pc_o, 12'h052); chk("stall_irq_ack", int_ack_o, 1'b0);
    op(4'b1111); chk("irq_ill_pc", pc_o, 12'hFF0); chk("irq_ill_ack", int_ack_o, 1'b1);
    chk("irq_ill_noill", illegal_o, 1'b0);
    irq_i = 1'b0;
    op(4'b1011); chk("reti2_pc", pc_o, 12'h052);
    op(4'b1101); chk("di_pc", pc_o, 12'h053); chk("di_en", int_en_o, 1'b0);
    irq_i = 1'b1;
    op(4'b0000); chk("di_irq_pc", pc_o, 12'h054); chk("di_irq_ack", int_ack_o, 1'b0);
    irq_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
